// File: rtl/jpeg_row_scheduler_if.sv
// ---------------------------------------------------------------------------
// jpeg_row_scheduler_if
// Bundle between the row sources and the jpeg_row_scheduler.
//   req      : per-source "row valid", held with row_data stable until row_ack
//   row_data : flattened rows, source i in slice i, lane k = sample k
//   grant    : one-hot owner of the serializer for the current block
//   row_ack  : one-cycle pulse, the source's row was captured
// Modports: master = scheduler side, slave = row-source side.
// ---------------------------------------------------------------------------
interface jpeg_row_scheduler_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ*8*(WIDTH+2)-1:0]  row_data;
    logic [NUM_REQ-1:0]              grant;
    logic [NUM_REQ-1:0]              row_ack;

    modport master (
        input  req,
        input  row_data,
        output grant,
        output row_ack
    );

    modport slave (
        output req,
        output row_data,
        input  grant,
        input  row_ack
    );
endinterface

// File: rtl/jpeg_row_scheduler.sv
// ---------------------------------------------------------------------------
// jpeg_row_scheduler
// Round-robin arbiter sharing one 8-lane parallel-to-serial row serializer
// between NUM_REQ row sources. The granted source keeps the serializer for a
// whole block of ROWS_PER_BLOCK rows; rows are issued on an 8-cycle cadence.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   src          : source bundle (req/row_data in, grant/row_ack out)
//   start        : one-cycle pulse to the serializer with a new out_row
//   out_row      : registered row, lane 0 in the LSBs
//   row_idx      : index of the row currently in out_row
//   block_done   : one-cycle pulse at block end
//   block_abort  : one-cycle pulse on a stall-timeout abort
//   busy         : high while a source owns the serializer
//
// Optional feature: define ROW_SCHED_STALL_TIMEOUT_EN to abort a block whose
// granted source leaves req low for STALL_LIMIT consecutive issue cycles.
// Without it the scheduler waits indefinitely and block_abort is 0.
// ---------------------------------------------------------------------------
module jpeg_row_scheduler #(
    parameter int WIDTH          = 8,
    parameter int NUM_REQ        = 3,
    parameter int ROWS_PER_BLOCK = 8,
    parameter int STALL_LIMIT    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    jpeg_row_scheduler_if.master      src,
    output logic                      start,
    output logic [8*(WIDTH+2)-1:0]    out_row,
    output logic [2:0]                row_idx,
    output logic                      block_done,
    output logic                      block_abort,
    output logic                      busy
);
    localparam int SW    = WIDTH + 2;
    localparam int ROW_W = 8 * SW;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {ARB, ISSUE, WAIT} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]         grant_q, grant_d;
    logic [NUM_REQ-1:0]         row_ack_q, row_ack_d;
    logic [2:0]                 row_cnt_q, row_cnt_d;
    logic [2:0]                 slot_q, slot_d;
    logic                       start_q, start_d;
    logic signed [ROW_W-1:0]    out_row_q, out_row_d;
    logic [2:0]                 row_idx_q, row_idx_d;
    logic                       done_q, done_d;
`ifdef ROW_SCHED_STALL_TIMEOUT_EN
    localparam int SC_W = $clog2(STALL_LIMIT + 1);
    logic [SC_W-1:0]            stall_q, stall_d;
    logic                       abort_q, abort_d;
`endif

    logic                       found;
    logic [IDX_W-1:0]           pick;
    logic [IDX_W-1:0]           cand;
    logic                       req_g;

    // rr_ptr doubles as the granted index for the duration of a block
    assign req_g = src.req[rr_ptr_q];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        row_ack_d = '0;
        row_cnt_d = row_cnt_q;
        slot_d    = slot_q;
        start_d   = 1'b0;
        out_row_d = out_row_q;
        row_idx_d = row_idx_q;
        done_d    = 1'b0;
`ifdef ROW_SCHED_STALL_TIMEOUT_EN
        stall_d   = stall_q;
        abort_d   = 1'b0;
`endif
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        // search starts one past the last owner, wrapping modulo NUM_REQ
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && src.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        case (state_q)
            ARB: begin
                if (found) begin
                    grant_d   = NUM_REQ'(1) << pick;
                    rr_ptr_d  = pick;
                    row_cnt_d = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (req_g) begin
                    out_row_d = src.row_data[rr_ptr_q*ROW_W +: ROW_W];
                    start_d   = 1'b1;
                    row_ack_d = grant_q;
                    row_idx_d = row_cnt_q;
                    // 6 + this cycle + the terminal WAIT cycle = 8-cycle cadence
                    slot_d    = 3'd6;
                    state_d   = WAIT;
`ifdef ROW_SCHED_STALL_TIMEOUT_EN
                    stall_d   = '0;
`endif
                end
`ifdef ROW_SCHED_STALL_TIMEOUT_EN
                else if (stall_q == SC_W'(STALL_LIMIT - 1)) begin
                    // this low cycle is the STALL_LIMIT-th in a row
                    abort_d   = 1'b1;
                    grant_d   = '0;
                    row_cnt_d = '0;
                    stall_d   = '0;
                    state_d   = ARB;
                end else begin
                    stall_d   = stall_q + 1'b1;
                end
`endif
            end
            WAIT: begin
                if (slot_q == 3'd0) begin
                    if (row_cnt_q == 3'(ROWS_PER_BLOCK - 1)) begin
                        done_d  = 1'b1;
                        grant_d = '0;
                        state_d = ARB;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                        state_d   = ISSUE;
                    end
                end else begin
                    slot_d = slot_q - 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB;
            rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
            grant_q   <= '0;
            row_ack_q <= '0;
            row_cnt_q <= '0;
            slot_q    <= '0;
            start_q   <= 1'b0;
            out_row_q <= '0;
            row_idx_q <= '0;
            done_q    <= 1'b0;
`ifdef ROW_SCHED_STALL_TIMEOUT_EN
            stall_q   <= '0;
            abort_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            row_ack_q <= row_ack_d;
            row_cnt_q <= row_cnt_d;
            slot_q    <= slot_d;
            start_q   <= start_d;
            out_row_q <= out_row_d;
            row_idx_q <= row_idx_d;
            done_q    <= done_d;
`ifdef ROW_SCHED_STALL_TIMEOUT_EN
            stall_q   <= stall_d;
            abort_q   <= abort_d;
`endif
        end
    end

    assign src.grant   = grant_q;
    assign src.row_ack = row_ack_q;
    assign start       = start_q;
    assign out_row     = out_row_q;
    assign row_idx     = row_idx_q;
    assign block_done  = done_q;
    assign busy        = |grant_q;
`ifdef ROW_SCHED_STALL_TIMEOUT_EN
    assign block_abort = abort_q;
`else
    // STALL_LIMIT has no effect without the timeout; referenced to keep it bound
    assign block_abort = 1'b0 & (STALL_LIMIT > 0);
`endif

endmodule

// File: tb/tb_jpeg_row_scheduler.sv
module tb_jpeg_row_scheduler;
    localparam int W     = 8;
    localparam int N     = 3;
    localparam int SW    = W + 2;
    localparam int ROW_W = 8 * SW;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ROW_W-1:0]  out_row;
    logic [2:0]        row_idx;
    logic              block_done;
    logic              block_abort;
    logic              busy;

    jpeg_row_scheduler_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

    jpeg_row_scheduler #(
        .WIDTH(W), .NUM_REQ(N), .ROWS_PER_BLOCK(8), .STALL_LIMIT(16)
    ) dut (
        .clk(clk), .rst(rst), .src(bus),
        .start(start), .out_row(out_row), .row_idx(row_idx),
        .block_done(block_done), .block_abort(block_abort), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tcnt   = 0;

    // source model state
    logic [ROW_W-1:0] rows [N][32];
    int               cnt  [N];
    int               ptr  [N];
    bit               en   [N];
    bit               hold [N];

    // observation logs
    int               st_tick  [$];
    logic [2:0]       st_idx   [$];
    logic [ROW_W-1:0] st_row   [$];
    logic [N-1:0]     st_grant [$];
    logic [N-1:0]     st_ack   [$];
    int               done_tick  [$];
    logic [N-1:0]     done_grant [$];
    int               abort_tick [$];
    logic [N-1:0]     abort_grant[$];
    int               first_ack [N];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [N-1:0]       r;
        logic [N*ROW_W-1:0] d;
        r = '0;
        d = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = en[i] && (ptr[i] < cnt[i]) && !hold[i];
            d[i*ROW_W +: ROW_W] = rows[i][ptr[i]];
        end
        bus.req      = r;
        bus.row_data = d;
    endtask

    task automatic tick();
        @(negedge clk);
        tcnt++;
        if (start) begin
            st_tick.push_back(tcnt);
            st_idx.push_back(row_idx);
            st_row.push_back(out_row);
            st_grant.push_back(bus.grant);
            st_ack.push_back(bus.row_ack);
        end
        if (block_done) begin
            done_tick.push_back(tcnt);
            done_grant.push_back(bus.grant);
        end
        if (block_abort) begin
            abort_tick.push_back(tcnt);
            abort_grant.push_back(bus.grant);
        end
        for (int i = 0; i < N; i++) begin
            if (bus.row_ack[i]) begin
                if (first_ack[i] < 0) first_ack[i] = tcnt;
                ptr[i]++;
            end
        end
        drive();
    endtask

    task automatic clear_logs();
        st_tick.delete(); st_idx.delete(); st_row.delete();
        st_grant.delete(); st_ack.delete();
        done_tick.delete(); done_grant.delete();
        abort_tick.delete(); abort_grant.delete();
        for (int i = 0; i < N; i++) first_ack[i] = -1;
    endtask

    task automatic setup_sources(input int c0, input int c1, input int c2);
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2;
        for (int i = 0; i < N; i++) begin
            ptr[i]  = 0;
            hold[i] = 1'b0;
            en[i]   = 1'b0;
            for (int r = 0; r < 32; r++)
                for (int l = 0; l < 8; l++)
                    rows[i][r][l*SW +: SW] = SW'($urandom);
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) en[i] = 1'b0;
        drive();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    // Reference: round-robin over sources with rows left, 8 rows per block,
    // starts 8 apart within a block, 9 apart across blocks, done 7 after last.
    task automatic verify_blocks(input string tag, input int nblk, input int first_start);
        int rp, src, k, prev, c;
        int pos [N];
        int rem [N];
        rp = N - 1;
        prev = 0;
        for (int i = 0; i < N; i++) begin
            pos[i] = 0;
            rem[i] = en[i] ? cnt[i] : 0;
        end
        chk({tag, "_starts"}, st_tick.size(), nblk * 8);
        chk({tag, "_dones"}, done_tick.size(), nblk);
        for (int b = 0; b < nblk; b++) begin
            src = 0;
            for (int j = N; j >= 1; j--) begin
                c = (rp + j) % N;
                if (rem[c] > 0) src = c;
            end
            rp = src;
            rem[src] -= 8;
            for (int r = 0; r < 8; r++) begin
                k = b * 8 + r;
                if (k >= st_tick.size()) break;
                if (k == 0)      chk({tag, "_start_tick"}, st_tick[k], first_start);
                else if (r == 0) chk({tag, "_block_gap"}, st_tick[k], prev + 9);
                else             chk({tag, "_row_gap"}, st_tick[k], prev + 8);
                chk({tag, "_row_idx"}, st_idx[k], r);
                chk({tag, "_out_row"}, st_row[k], rows[src][pos[src]]);
                chk({tag, "_grant"}, st_grant[k], N'(1) << src);
                chk({tag, "_row_ack"}, st_ack[k], N'(1) << src);
                pos[src]++;
                prev = st_tick[k];
            end
            if (b < done_tick.size()) begin
                chk({tag, "_done_tick"}, done_tick[b], prev + 7);
                chk({tag, "_done_grant"}, done_grant[b], 0);
            end
        end
    endtask

    initial begin
        int t0, s;
        rst = 1'b1;
        setup_sources(0, 0, 0);
        clear_logs();
        drive();
        tick();
        tick();

        // reset state
        chk("rst_grant", bus.grant, 0);
        chk("rst_row_ack", bus.row_ack, 0);
        chk("rst_start", start, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_row_idx", row_idx, 0);
        chk("rst_done", block_done, 0);
        chk("rst_abort", block_abort, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        clear_logs();

        // single source, one block
        setup_sources(8, 0, 0);
        en[0] = 1'b1;
        drive();
        t0 = tcnt;
        tick();
        chk("t1_grant_e1", bus.grant, 3'b001);
        chk("t1_busy_e1", busy, 1);
        for (int n = 0; n < 100 && done_tick.size() < 1; n++) tick();
        repeat (4) tick();
        verify_blocks("t1", 1, t0 + 2);

        // all three requesting: order 0,1,2,0
        setup_sources(16, 8, 8);
        do_reset();
        en[0] = 1'b1; en[1] = 1'b1; en[2] = 1'b1;
        drive();
        t0 = tcnt;
        for (int n = 0; n < 400 && done_tick.size() < 4; n++) tick();
        repeat (4) tick();
        verify_blocks("t2", 4, t0 + 2);

        // requester 1 raised mid-block of requester 0
        setup_sources(8, 8, 0);
        do_reset();
        en[0] = 1'b1;
        drive();
        for (int n = 0; n < 60 && st_tick.size() < 3; n++) tick();
        en[1] = 1'b1;
        drive();
        for (int n = 0; n < 150 && st_tick.size() < 9; n++) tick();
        chk("t3_progress", st_tick.size() >= 9 && done_tick.size() >= 1, 1);
        if (st_tick.size() >= 9 && done_tick.size() >= 1) begin
            chk("t3_no_early_ack", first_ack[1] > done_tick[0], 1);
            chk("t3_next_grant", st_grant[8], 3'b010);
            chk("t3_next_gap", st_tick[8], st_tick[7] + 9);
            chk("t3_next_idx", st_idx[8], 0);
            chk("t3_next_row", st_row[8], rows[1][0]);
        end

        // granted req low for 5 cycles before row 3
        setup_sources(8, 0, 0);
        do_reset();
        en[0] = 1'b1;
        drive();
        for (int n = 0; n < 60 && st_tick.size() < 3; n++) tick();
        chk("t4_progress", st_tick.size(), 3);
        s = st_tick[2];
        for (int n = 0; n < 20 && tcnt < s + 7; n++) tick();
        hold[0] = 1'b1;
        drive();
        repeat (5) begin
            tick();
            chk("t4_stall_grant", bus.grant, 3'b001);
            chk("t4_stall_start", start, 0);
        end
        hold[0] = 1'b0;
        drive();
        for (int n = 0; n < 100 && done_tick.size() < 1; n++) tick();
        chk("t4_starts", st_tick.size(), 8);
        if (st_tick.size() >= 5) begin
            chk("t4_row3_tick", st_tick[3], s + 13);
            chk("t4_row3_idx", st_idx[3], 3);
            chk("t4_row3_data", st_row[3], rows[0][3]);
            chk("t4_row4_gap", st_tick[4], st_tick[3] + 8);
        end

        // reset pulsed during row 4
        setup_sources(8, 8, 8);
        do_reset();
        en[0] = 1'b1;
        drive();
        for (int n = 0; n < 60 && st_tick.size() < 5; n++) tick();
        chk("t5_progress", st_tick.size(), 5);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t5_grant", bus.grant, 0);
        chk("t5_start", start, 0);
        chk("t5_out_row", out_row, 0);
        chk("t5_row_idx", row_idx, 0);
        chk("t5_busy", busy, 0);
        en[0] = 1'b0; en[1] = 1'b1; en[2] = 1'b1;
        clear_logs();
        drive();
        tick();
        rst = 1'b0;
        for (int n = 0; n < 20 && st_tick.size() < 1; n++) tick();
        chk("t5_no_done", done_tick.size(), 0);
        chk("t5_started", st_tick.size(), 1);
        if (st_tick.size() >= 1) begin
            chk("t5_grant_after", st_grant[0], 3'b010);
            chk("t5_idx_after", st_idx[0], 0);
            chk("t5_row_after", st_row[0], rows[1][0]);
        end

        // granted req low for 16 cycles (STALL_LIMIT=16)
        setup_sources(8, 8, 0);
        do_reset();
        en[0] = 1'b1; en[1] = 1'b1;
        drive();
        for (int n = 0; n < 40 && st_tick.size() < 2; n++) tick();
        chk("t6_progress", st_tick.size(), 2);
        s = st_tick[1];
        for (int n = 0; n < 20 && tcnt < s + 7; n++) tick();
        hold[0] = 1'b1;
        drive();
        repeat (16) tick();
        hold[0] = 1'b0;
        drive();
        for (int n = 0; n < 40 && st_tick.size() < 3; n++) tick();
        chk("t6_started", st_tick.size(), 3);
`ifdef ROW_SCHED_STALL_TIMEOUT_EN
        chk("t6_abort_count", abort_tick.size(), 1);
        if (abort_tick.size() >= 1) begin
            chk("t6_abort_tick", abort_tick[0], s + 23);
            chk("t6_abort_grant", abort_grant[0], 0);
        end
        if (st_tick.size() >= 3) begin
            chk("t6_next_grant", st_grant[2], 3'b010);
            chk("t6_next_tick", st_tick[2], s + 25);
            chk("t6_next_idx", st_idx[2], 0);
        end
`else
        chk("t6_abort_count", abort_tick.size(), 0);
        if (st_tick.size() >= 3) begin
            chk("t6_next_grant", st_grant[2], 3'b001);
            chk("t6_next_tick", st_tick[2], s + 24);
            chk("t6_next_idx", st_idx[2], 2);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jpeg_row_scheduler.md
# jpeg_row_scheduler

Round-robin scheduler that shares one 8-pixel parallel-to-serial row serializer between up to NUM_REQ row sources (for example Y, Cb and Cr level-shifted row buffers). A granted source keeps the serializer for a whole 8x8 block, so the downstream DCT/zigzag path always sees 64 contiguous samples from one component. The block issues the serializer's Start pulse and row bus at a fixed 8-cycle cadence and handshakes every row with its source.

## Interface
- WIDTH, 8: pixel width. Each sample is WIDTH+2 bits, signed.
- NUM_REQ, 3: number of requesters, 2..8.
- ROWS_PER_BLOCK, 8: rows per block.
- STALL_LIMIT, 64: stall-timeout threshold in cycles. Used only when the timeout macro is defined.
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  NUM_REQ  per-source "row valid". Held high with Row_Data stable until Row_Ack.
- Row_Data  in  NUM_REQ*8*(WIDTH+2)  flattened rows. Source i occupies slice i; lane k within a slice is sample k.
- Grant  out  NUM_REQ  one-hot owner of the serializer for the current block.
- Row_Ack  out  NUM_REQ  one-cycle pulse: the row was captured.
- Start  out  1  one-cycle pulse to the serializer.
- Out_Row  out  8*(WIDTH+2)  registered row to the serializer, lane 0 in the LSBs.
- Row_Idx  out  3  index of the row currently in Out_Row, 0..ROWS_PER_BLOCK-1.
- Block_Done  out  1  one-cycle pulse at block end.
- Block_Abort  out  1  one-cycle pulse on a timeout abort.
- Busy  out  1  high whenever Grant is nonzero.

## Operation
- The FSM has three states: ARB, ISSUE and WAIT. Reset puts it in ARB.
- **ARB**
  - If any Req is high, pick the first requester with Req set, searching from rr_ptr+1 modulo NUM_REQ.
  - Set Grant to that requester, load rr_ptr with its index, clear the row count, and go to ISSUE.
  - If no Req is high, stay in ARB.
- **ISSUE**, with g the granted index:
  - If Req[g]=1: register Row_Data slice g into Out_Row, assert Start and Row_Ack[g] in the next cycle, load Row_Idx with the row count, load the slot counter with 6, and go to WAIT.
  - If Req[g]=0: stall in ISSUE. Start stays 0, Grant is held, and no other requester is served.
- **WAIT**
  - Decrement the slot counter.
  - At 0, if the row count is ROWS_PER_BLOCK-1: go to ARB, pulse Block_Done, and clear Grant.
  - At 0 otherwise: increment the row count and go to ISSUE.
- Req of requesters that are not granted is ignored. No Row_Ack is issued to them.
- rr_ptr resets to NUM_REQ-1, so requester 0 has the highest priority first.
- Out_Row holds its value between Starts. It is not cleared at block end.

## Timing
- Reset values: every output is 0, state is ARB, rr_ptr is NUM_REQ-1, row count is 0, slot counter is 0.
- Reset asserted mid-block:
  - The current block is abandoned immediately.
  - No Block_Done is generated.
  - Arbitration restarts at requester 0.
- Req sampled high in ARB at edge e:
  - Grant is high from e+1.
  - The first Start is at e+2.
- Within a block, consecutive Starts are exactly 8 cycles apart when Req is never low in ISSUE. This matches the serializer's 8-cycle occupancy, so Start lands while the serializer is outputting lane 7.
- Each cycle spent stalled in ISSUE adds one cycle between Starts.
- Row_Ack[g] coincides with Start. The source may present its next row from the following cycle.
- If the last Start of a block is in cycle s:
  - Block_Done is high in cycle s+7, and Grant goes to 0 in that same cycle.
  - The earliest next-block Start is s+9.
- Row_Idx changes only in the Start cycle.

## Configuration
- ROW_SCHED_STALL_TIMEOUT_EN defined:
  - A counter increments on each consecutive ISSUE cycle with Req[g]=0 and clears on a Start.
  - When it reaches STALL_LIMIT: pulse Block_Abort for one cycle, clear Grant and the row count, and go to ARB.
  - rr_ptr stays at the aborting requester, so the next search starts after it.
- ROW_SCHED_STALL_TIMEOUT_EN undefined: ISSUE waits indefinitely, Block_Abort is tied to 0, and STALL_LIMIT is unused.

## Test plan
- Reset, then Req=3'b001 held high with 8 distinct rows:
  - Grant=001.
  - 8 Starts at e+2, e+10, …, e+58.
  - Row_Idx runs 0..7 in those cycles.
  - Out_Row matches each row.
  - Block_Done fires once, 7 cycles after the last Start.
- Req=3'b111 held continuously: blocks are granted in the order 0, 1, 2, 0, and each block's first Start is 9 cycles after the previous block's last Start.
- Req[1] raised mid-block of requester 0: no Row_Ack[1] until requester 0's Block_Done, after which Grant=010.
- Granted Req drops for 5 cycles before row 3:
  - The Start of row 3 is delayed by 5 cycles.
  - Grant is held.
  - Row_Idx=3 on that Start.
- Reset pulsed during row 4: all outputs go to 0 immediately. After release with Req=3'b110, Grant=010 and Row_Idx restarts at 0.
- With ROW_SCHED_STALL_TIMEOUT_EN and STALL_LIMIT=16, granted Req low for 16 cycles:
  - Block_Abort fires once.
  - Grant clears.
  - The next pending requester is granted.
  - With the macro undefined, the same stimulus gives no abort.
